// File: rtl/apb_master.sv
// apb_master: single-command APB requester.
// Takes one read or write at a time on a valid/ready command port and runs it
// through the APB IDLE -> SETUP -> ACCESS sequence. A RDWAIT state covers the
// registered read data from the downstream slave. Each accepted command gets a
// one-cycle response strobe.
// Optional build macro APB_TIMEOUT_EN: aborts an ACCESS phase after
// TIMEOUT_CYCLES cycles with pready low and reports it on rsp_err.
module apb_master #(
   parameter int ADDRWIDTH      = 5,
   parameter int DATAWIDTH      = 8,
   parameter int RD_LATENCY     = 1,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                 pclk,
   input  logic                 preset,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic                 cmd_write,
   input  logic [ADDRWIDTH-1:0] cmd_addr,
   input  logic [DATAWIDTH-1:0] cmd_wdata,
   output logic                 rsp_valid,
   output logic [DATAWIDTH-1:0] rsp_rdata,
   output logic                 rsp_err,
   output logic                 psel,
   output logic                 penable,
   output logic                 pwrite,
   output logic [ADDRWIDTH-1:0] paddress,
   output logic [DATAWIDTH-1:0] pwdata,
   input  logic [DATAWIDTH-1:0] prdata,
   input  logic                 pready
);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RDWAIT} state_t;

   // Value of the read-latency counter on the edge that samples prdata.
   localparam logic [1:0] LatLast = 2'((RD_LATENCY > 0) ? RD_LATENCY - 1 : 0);

   state_t                 state_q, state_d;
   logic                   pwrite_q, pwrite_d;
   logic [ADDRWIDTH-1:0]   paddr_q, paddr_d;
   logic [DATAWIDTH-1:0]   pwdata_q, pwdata_d;
   logic                   rsp_valid_q, rsp_valid_d;
   logic [DATAWIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
   logic [1:0]             lat_cnt_q, lat_cnt_d;

`ifdef APB_TIMEOUT_EN
   localparam int ToW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [ToW-1:0] ToLast = ToW'(TIMEOUT_CYCLES - 1);

   logic [ToW-1:0]         to_cnt_q, to_cnt_d;
   logic                   rsp_err_q, rsp_err_d;
`endif

   // State register plus the held APB request and response registers.
   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         state_q     <= IDLE;
         pwrite_q    <= 1'b0;
         paddr_q     <= '0;
         pwdata_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         lat_cnt_q   <= '0;
`ifdef APB_TIMEOUT_EN
         to_cnt_q    <= '0;
         rsp_err_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         pwrite_q    <= pwrite_d;
         paddr_q     <= paddr_d;
         pwdata_q    <= pwdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         lat_cnt_q   <= lat_cnt_d;
`ifdef APB_TIMEOUT_EN
         to_cnt_q    <= to_cnt_d;
         rsp_err_q   <= rsp_err_d;
`endif
      end
   end

   // Next-state logic: latch the command, step the APB phases and build the response.
   always_comb begin
      state_d     = state_q;
      pwrite_d    = pwrite_q;
      paddr_d     = paddr_q;
      pwdata_d    = pwdata_q;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = rsp_rdata_q;
      lat_cnt_d   = lat_cnt_q;
`ifdef APB_TIMEOUT_EN
      to_cnt_d    = to_cnt_q;
      rsp_err_d   = rsp_err_q;
`endif
      case (state_q)
         IDLE: begin
            if (cmd_valid && cmd_ready) begin
               pwrite_d = cmd_write;
               paddr_d  = cmd_addr;
               pwdata_d = cmd_wdata;
               state_d  = SETUP;
`ifdef APB_TIMEOUT_EN
               to_cnt_d = '0;
`endif
            end
         end
         SETUP: begin
            state_d = ACCESS;
         end
         ACCESS: begin
            if (pready) begin
`ifdef APB_TIMEOUT_EN
               rsp_err_d = 1'b0;
`endif
               if (pwrite_q) begin
                  rsp_valid_d = 1'b1;
                  rsp_rdata_d = '0;
                  state_d     = IDLE;
               end else if (RD_LATENCY == 0) begin
                  rsp_valid_d = 1'b1;
                  rsp_rdata_d = prdata;
                  state_d     = IDLE;
               end else begin
                  lat_cnt_d = '0;
                  state_d   = RDWAIT;
               end
            end
`ifdef APB_TIMEOUT_EN
            else if (to_cnt_q == ToLast) begin
               rsp_valid_d = 1'b1;
               rsp_rdata_d = '0;
               rsp_err_d   = 1'b1;
               state_d     = IDLE;
            end else begin
               to_cnt_d = to_cnt_q + 1'b1;
            end
`endif
         end
         RDWAIT: begin
            if (lat_cnt_q == LatLast) begin
               rsp_valid_d = 1'b1;
               rsp_rdata_d = prdata;
               state_d     = IDLE;
`ifdef APB_TIMEOUT_EN
               rsp_err_d   = 1'b0;
`endif
            end else begin
               lat_cnt_d = lat_cnt_q + 2'd1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // cmd_ready is held low while reset is asserted so a command can never slip in.
   assign cmd_ready = (state_q == IDLE) && !preset;
   assign psel      = (state_q == SETUP) || (state_q == ACCESS);
   assign penable   = (state_q == ACCESS);
   assign pwrite    = pwrite_q;
   assign paddress  = paddr_q;
   assign pwdata    = pwdata_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
`ifdef APB_TIMEOUT_EN
   assign rsp_err   = rsp_err_q;
`else
   assign rsp_err   = 1'b0;
`endif

endmodule
